chasy_time_uart_tx: RTL
=======================

Name: chasy_time_uart_tx

Overview:
Serial transmitter that reports clock time to a host PC, in the opposite direction to the button inputs. It takes the packed BCD time word from the real-time clock and sends it as ASCII "HH:MM:SS\r\n" over UART 8N1. Messages start on an explicit request pulse, or automatically whenever the time changes. It sits in the top level beside the display and is driven by the same data_ch bus.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
BAUD, 115200, line rate in bits per second.
CLKS_PER_BIT (localparam), CLK_HZ/BAUD with integer truncation, clock cycles per UART bit; must be >= 2.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
data_ch  in  24  BCD time {Ht,Hu,Mt,Mu,St,Su}, 4 bits per digit, Ht in [23:20]
send  in  1  one-cycle request to transmit one message
auto_en  in  1  when 1, any change of data_ch requests a message
txd  out  1  UART serial output, idle high
busy  out  1  high from request acceptance until the last stop bit ends
done  out  1  one-cycle pulse when a message completes

Behaviour:
- Reset values: txd=1, busy=0, done=0, pending=0, FSM=IDLE, previous-time register loaded with data_ch.
- Request sources:
  - send=1.
  - auto_en=1 and data_ch != prev_ch. prev_ch updates every cycle.
  - Both in the same cycle count as one request.
- Accept:
  - In IDLE, a request is accepted on that edge. data_ch is snapshotted, busy=1, char index=0.
  - On the next edge, txd=0 (start bit). Latency from request to start bit is 1 cycle.
- Snapshot rule: the message always reflects the time at acceptance. Changes to data_ch mid-message do not alter the bytes being sent.
- Message: 10 bytes, in order: ASCII(Ht), ASCII(Hu), 0x3A, ASCII(Mt), ASCII(Mu), 0x3A, ASCII(St), ASCII(Su), 0x0D, 0x0A.
- Digit encoding: digit 0-9 maps to 0x30+digit. Digits 0xA-0xF map to 0x3F ('?').
- Byte frame:
  - START: 1 bit low.
  - DATA: 8 bits, LSB first.
  - STOP: 1 bit high.
  - Each bit lasts exactly CLKS_PER_BIT cycles. No idle gap between bytes inside a message.
- FSM: IDLE -> START -> DATA(bit 0..7) -> STOP.
  - After STOP, go back to START with index+1 if index<9.
  - After STOP with index=9, go to IDLE. done=1 for one cycle on that edge and busy drops on the same edge.
- Total message duration is 100*CLKS_PER_BIT cycles from the start bit to the end of the last stop bit.
- Request while busy:
  - Sets a one-deep pending flag. Further requests while pending are coalesced.
  - On completion, a pending request is accepted in the same cycle as done: new snapshot, busy stays 1, pending clears.
  - The next start bit follows with 1-cycle latency, so the inter-message gap is 1 cycle of idle-high txd.
- Reset mid-message: on the next edge txd=1 and busy=0, with no partial-byte completion. pending and done are cleared.
- The bit counter and the baud counter never wrap unchecked. The baud counter counts 0..CLKS_PER_BIT-1 and reloads.

Decomposition:
- Package chasy_pkg holds:
  - ASCII_COLON=8'h3A, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_QMARK=8'h3F, ASCII_ZERO=8'h30.
  - MSG_LEN=10.
  - The tx_state_t enum {IDLE, START, DATA, STOP}.
  - A function bcd_to_ascii(logic [3:0]) returning logic [7:0].
- Sub-module uart_byte_tx: handles byte framing and baud timing.
  - Inputs: start, byte_in.
  - Outputs: txd, byte_done.
- The parent handles snapshot, message sequencing, pending and auto detection.

Test Plan:
1. Message content and timing: CLK_HZ=160, BAUD=10 (CLKS_PER_BIT=16), data_ch=24'h123456, pulse send.
   - Start bit at the next cycle.
   - Decoded bytes are 31 32 3A 33 34 3A 35 36 0D 0A.
   - Each bit lasts 16 cycles.
   - done pulses exactly 1600 cycles after the start bit began, and busy=0 on that edge.
2. Invalid digit: data_ch=24'h1A5900 -> second byte is 0x3F; all other bytes correct.
3. Back-to-back requests: pulse send 3 times during message 1, with data_ch changed to 24'h000001 in between.
   - Message 1 still holds the original time.
   - Exactly one more message follows, carrying 24'h000001, after a 1-cycle idle gap.
   - busy never drops between the two messages.
4. Auto mode:
   - auto_en=1, data_ch goes 235959 -> 000000 -> one message "00:00:00\r\n".
   - data_ch held constant for 5000 cycles -> no further messages.
   - With auto_en=0, a data_ch change -> no message.
5. Simultaneous sources: send=1 in the same cycle as a data_ch change with auto_en=1 -> exactly one message.
6. Reset mid-frame: assert reset during DATA bit 3 of byte 4.
   - Next edge: txd=1, busy=0, done=0.
   - Stays idle after release until a new send, which yields a complete, correct message.

Source files
------------

// File: rtl/chasy_pkg.sv
// Shared constants, FSM encoding and digit-to-ASCII helper for the clock-time
// UART reporter.
package chasy_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int MSG_LEN = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Non-decimal nibbles are shown as '?' so a corrupt time is visible on the host.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    if (digit <= 4'd9) return ASCII_ZERO + {4'd0, digit};
    else               return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte framer: start bit, eight data bits LSB first, stop bit, each bit
// held for CLKS_PER_BIT clocks. A start request in the last stop cycle chains
// the next byte with no idle gap.
module uart_byte_tx
  import chasy_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte_in,
  output logic       o_txd,
  output logic       o_byte_done,
  output tx_state_t  o_state
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  tx_state_t     w_state_n;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_n;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic          r_txd;
  logic          w_txd_n;
  logic          w_baud_last;
  logic          w_byte_done;

  assign w_baud_last = (r_baud == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_txd   <= w_txd_n;
    end
  end

  // The line level for each bit is registered one edge ahead, so o_txd is glitch-free.
  always_comb begin
    w_state_n   = r_state;
    w_baud_n    = r_baud;
    w_bit_n     = r_bit;
    w_shift_n   = r_shift;
    w_txd_n     = r_txd;
    w_byte_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_n = 1'b1;
        if (i_start) begin
          w_state_n = START;
          w_baud_n  = '0;
          w_shift_n = i_byte_in;
          w_txd_n   = 1'b0;
        end
      end
      START: begin
        if (w_baud_last) begin
          w_state_n = DATA;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_txd_n   = r_shift[0];
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_last) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_state_n = STOP;
            w_txd_n   = 1'b1;
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
            w_txd_n   = r_shift[1];
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_last) begin
          w_byte_done = 1'b1;
          w_baud_n    = '0;
          if (i_start) begin
            w_state_n = START;
            w_shift_n = i_byte_in;
            w_txd_n   = 1'b0;
          end else begin
            w_state_n = IDLE;
            w_txd_n   = 1'b1;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_txd_n   = 1'b1;
      end
    endcase
  end

  assign o_txd       = r_txd;
  assign o_byte_done = w_byte_done;
  assign o_state     = r_state;

endmodule

// File: rtl/chasy_time_uart_tx.sv
// Sends the BCD clock time as ASCII "HH:MM:SS\r\n" over UART 8N1, on a send
// pulse or on any time change while auto_en is set.
module chasy_time_uart_tx
  import chasy_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] data_ch,
  input  logic        send,
  input  logic        auto_en,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  // Must come out >= 2 for the framer's baud counter to make sense.
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [23:0] r_prev;
  logic [23:0] r_snap;
  logic [3:0]  r_idx;
  logic        r_busy;
  logic        r_pending;
  logic        r_done;
  logic        r_kick;

  logic        w_req;
  logic        w_accept;
  logic        w_byte_done;
  logic        w_last_byte;
  logic        w_tx_start;
  logic [3:0]  w_sel_idx;
  logic [7:0]  w_tx_byte;
  logic        w_txd;
  tx_state_t   w_tx_state;

  assign w_req       = send | (auto_en & (data_ch != r_prev));
  assign w_last_byte = w_byte_done & (r_idx == 4'(MSG_LEN - 1));
  // A queued or coincident request restarts on the completion edge, keeping busy high.
  assign w_accept    = (~r_busy & w_req) | (w_last_byte & (r_pending | w_req));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev    <= data_ch;
      r_snap    <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_kick    <= 1'b0;
    end else begin
      r_prev <= data_ch;
      r_done <= w_last_byte;
      r_kick <= w_accept;
      if (w_accept) begin
        r_snap    <= data_ch;
        r_idx     <= '0;
        r_busy    <= 1'b1;
        r_pending <= 1'b0;
      end else begin
        if (w_last_byte) r_busy <= 1'b0;
        if (w_byte_done && !w_last_byte) r_idx <= r_idx + 4'd1;
        if (r_busy && w_req) r_pending <= 1'b1;
      end
    end
  end

  // r_kick launches byte 0 one cycle after acceptance; later bytes chain on byte_done.
  assign w_tx_start = r_kick | (w_byte_done & ~w_last_byte);
  assign w_sel_idx  = r_kick ? 4'd0 : (r_idx + 4'd1);

  always_comb begin
    w_tx_byte = ASCII_LF;
    case (w_sel_idx)
      4'd0:    w_tx_byte = bcd_to_ascii(r_snap[23:20]);
      4'd1:    w_tx_byte = bcd_to_ascii(r_snap[19:16]);
      4'd2:    w_tx_byte = ASCII_COLON;
      4'd3:    w_tx_byte = bcd_to_ascii(r_snap[15:12]);
      4'd4:    w_tx_byte = bcd_to_ascii(r_snap[11:8]);
      4'd5:    w_tx_byte = ASCII_COLON;
      4'd6:    w_tx_byte = bcd_to_ascii(r_snap[7:4]);
      4'd7:    w_tx_byte = bcd_to_ascii(r_snap[3:0]);
      4'd8:    w_tx_byte = ASCII_CR;
      default: w_tx_byte = ASCII_LF;
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_tx_start),
    .i_byte_in  (w_tx_byte),
    .o_txd      (w_txd),
    .o_byte_done(w_byte_done),
    .o_state    (w_tx_state)
  );

  // Whenever no message is in flight the framer must be parked in IDLE.
  always_ff @(posedge clock) begin
    if (!reset && !r_busy) assert (w_tx_state == IDLE);
  end

  assign txd  = w_txd;
  assign busy = r_busy;
  assign done = r_done;

endmodule
